// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo: PS/2 keyboard receiver with clock glitch filter, frame checking,
// E0/F0 prefix decoding and a show-ahead FIFO of decoded scan codes.
// Ports:
//   clk, rst (sync, active-low)       system clock and reset
//   ps2c, ps2d                        raw asynchronous PS/2 clock and data
//   rd_en                             pop the head entry (ignored while empty)
//   clr_err                           clear sticky error flags (a set in the same cycle wins)
//   code_valid/code/is_ext/is_break   head entry, zero while empty
//   empty/full/count                  FIFO occupancy
//   overflow/parity_err/frame_err     sticky error flags
//   debug_out                         {8'h0, ovf, perr, ferr, is_break, count[3:0], last byte, code}
module ps2_kbd_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2c,
    input  logic                  ps2d,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic                  code_valid,
    output logic [7:0]            code,
    output logic                  is_ext,
    output logic                  is_break,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic [31:0]           debug_out
);
    localparam int N  = 1 << DEPTH_LOG2;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            c_q, d_q;
    logic [FILTER_LEN-1:0] flt_q;
    logic                  fclk_q;
    logic                  fall, din;
    state_t                st_q;
    logic [2:0]            bit_q;
    logic [7:0]            sr_q, byte_q, last_q;
    logic                  par_q, done_q;
    logic [TW-1:0]         tmr_q;
    logic                  perr_q, ferr_q, ovf_q, ext_q, brk_q;
    logic [9:0]            mem_q [N];
    logic [DEPTH_LOG2-1:0] wp_q, rp_q;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  push_req, push, pop;
    logic [9:0]            head;

    // Two-flop synchronisers feeding the clock glitch filter; the filtered
    // clock only moves once FILTER_LEN consecutive samples agree.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_q    <= 2'b11;
            d_q    <= 2'b11;
            flt_q  <= '1;
            fclk_q <= 1'b1;
        end else begin
            c_q    <= {c_q[0], ps2c};
            d_q    <= {d_q[0], ps2d};
            flt_q  <= {flt_q[FILTER_LEN-2:0], c_q[1]};
            fclk_q <= (&flt_q) ? 1'b1 : (~|flt_q) ? 1'b0 : fclk_q;
        end
    end

    assign fall = fclk_q & ~|flt_q;
    assign din  = d_q[1];

    // Frame FSM. Flag clears are written first so a set later in the block wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= IDLE;
            bit_q  <= '0;
            sr_q   <= '0;
            par_q  <= 1'b0;
            tmr_q  <= '0;
            done_q <= 1'b0;
            byte_q <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_err) begin
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (st_q != IDLE && tmr_q == TW'(TIMEOUT)) begin
                st_q   <= IDLE;
                tmr_q  <= '0;
                ferr_q <= 1'b1;
            end else if (fall) begin
                tmr_q <= '0;
                case (st_q)
                    IDLE: if (!din) begin
                        st_q  <= DATA;
                        bit_q <= '0;
                    end
                    DATA: begin
                        sr_q  <= {din, sr_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) st_q <= PARITY;
                    end
                    PARITY: begin
                        par_q <= din;
                        st_q  <= STOP;
                    end
                    STOP: begin
                        st_q <= IDLE;
                        if (^{sr_q, par_q} && din) begin
                            done_q <= 1'b1;
                            byte_q <= sr_q;
                        end
                        if (!(^{sr_q, par_q})) perr_q <= 1'b1;
                        if (!din) ferr_q <= 1'b1;
                    end
                endcase
            end else if (st_q != IDLE) begin
                tmr_q <= tmr_q + TW'(1);
            end
        end
    end

    // A push while full succeeds only if a pop frees a slot in the same cycle.
    assign push_req = done_q && byte_q != 8'hE0 && byte_q != 8'hF0;
    assign pop      = rd_en & ~empty;
    assign push     = push_req & (~full | pop);
    assign cnt_d    = cnt_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            last_q <= '0;
            ovf_q  <= 1'b0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (clr_err) ovf_q <= 1'b0;
            if (done_q) begin
                last_q <= byte_q;
                if (byte_q == 8'hE0) ext_q <= 1'b1;
                else if (byte_q == 8'hF0) brk_q <= 1'b1;
                else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (!push) ovf_q <= 1'b1;
                end
            end
            if (push) wp_q <= wp_q + DEPTH_LOG2'(1);
            if (pop) rp_q <= rp_q + DEPTH_LOG2'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {ext_q, brk_q, byte_q};
    end

    assign empty      = cnt_q == '0;
    assign full       = cnt_q == (DEPTH_LOG2+1)'(N);
    assign count      = cnt_q;
    assign head       = empty ? 10'd0 : mem_q[rp_q];
    assign code_valid = ~empty;
    assign code       = head[7:0];
    assign is_break   = head[8];
    assign is_ext     = head[9];
    assign overflow   = ovf_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign debug_out  = {8'h00, ovf_q, perr_q, ferr_q, head[8], 4'(cnt_q), last_q, head[7:0]};
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// tb_ps2_kbd_fifo: randomized self-checking bench for ps2_kbd_fifo against a queue-based model.
module tb_ps2_kbd_fifo;
    logic        clk = 1'b0, rst = 1'b0, ps2c = 1'b1, ps2d = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic        code_valid, is_ext, is_break, empty, full, overflow, parity_err, frame_err;
    logic [7:0]  code;
    logic [3:0]  count;
    logic [31:0] debug_out;
    logic [19:0] obs;

    logic [9:0]  q[$];
    logic        ext_m, brk_m, ovf_m, perr_m, ferr_m;
    logic [7:0]  last_m;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    ps2_kbd_fifo #(.DEPTH_LOG2(3), .FILTER_LEN(4), .TIMEOUT(300)) dut (
        .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .rd_en(rd_en), .clr_err(clr_err),
        .code_valid(code_valid), .code(code), .is_ext(is_ext), .is_break(is_break),
        .empty(empty), .full(full), .count(count), .overflow(overflow),
        .parity_err(parity_err), .frame_err(frame_err), .debug_out(debug_out)
    );

    assign obs = {code_valid, is_ext, full, empty, count, code, is_break, overflow, parity_err, frame_err};

    function automatic logic [9:0] head_m();
        return (q.size() != 0) ? q[0] : 10'd0;
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [9:0] h = head_m();
        return {q.size() != 0, h[9], q.size() == 8, q.size() == 0, 4'(q.size()), h[7:0], h[8], ovf_m, perr_m, ferr_m};
    endfunction

    function automatic logic [31:0] exp_dbg();
        logic [9:0] h = head_m();
        return {8'h00, ovf_m, perr_m, ferr_m, h[8], 4'(q.size()), last_m, h[7:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        {ext_m, brk_m, ovf_m, perr_m, ferr_m} = '0;
        last_m = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        last_m = b;
        if (b == 8'hE0) ext_m = 1'b1;
        else if (b == 8'hF0) brk_m = 1'b1;
        else begin
            if (q.size() < 8) q.push_back({ext_m, brk_m, b});
            else ovf_m = 1'b1;
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        ps2d = b;
        cyc(20);
        ps2c = 1'b0;
        cyc(20);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(~^b ^ bad_par);
        drive_bit(~bad_stop);
        ps2d = 1'b1;
        cyc(30);
        if (!bad_par && !bad_stop) model_byte(b);
        perr_m |= bad_par;
        ferr_m |= bad_stop;
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        {ovf_m, perr_m, ferr_m} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        model_reset();
        cyc(3);
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        cyc(3);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL reset_hold obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        rst = 1'b1;
        cyc(5);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL reset_release obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
    endtask

    task automatic test_make();
        send_frame(8'h1C, 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL make_code obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        do_read();
        total++;
        if (obs !== exp_vec() || empty !== 1'b1)
            $display("FAIL make_read obs=%h exp=%h", obs, exp_vec());
        else passed++;
    endtask

    task automatic test_ext_break();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL ext_prefix_only obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        send_frame(8'h75, 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg() || {is_ext, is_break, code} !== 10'h375)
            $display("FAIL ext_break obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        do_read();
    endtask

    task automatic test_bad_frames();
        send_frame(8'h1C, 1'b1, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL bad_parity obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        send_frame(8'h1C, 1'b0, 1'b1);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL bad_stop obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        do_clr();
        total++;
        if (obs !== exp_vec() || {parity_err, frame_err} !== 2'b00)
            $display("FAIL clr_err obs=%h exp=%h", obs, exp_vec());
        else passed++;
        send_frame(8'h5A, 1'b1, 1'b1);
        total++;
        if (obs !== exp_vec() || {parity_err, frame_err} !== 2'b11)
            $display("FAIL both_bad obs=%h exp=%h", obs, exp_vec());
        else passed++;
        do_clr();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg() || {full, count, overflow} !== 6'b1_1000_1)
            $display("FAIL overflow_fill obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (obs !== exp_vec() || code !== 8'(i))
                $display("FAIL overflow_read%0d obs=%h exp=%h code=%h", i, obs, exp_vec(), code);
            else passed++;
            do_read();
        end
        total++;
        if (obs !== exp_vec() || empty !== 1'b1)
            $display("FAIL overflow_drained obs=%h exp=%h", obs, exp_vec());
        else passed++;
        do_clr();
    endtask

    task automatic test_glitch_timeout();
        ps2d = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ps2c = 1'b0;
            cyc(2);
            ps2c = 1'b1;
            cyc(10);
        end
        ps2d = 1'b1;
        cyc(10);
        send_frame(8'h3B, 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL glitch_filter obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        do_read();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        ps2d = 1'b1;
        cyc(400);
        ferr_m = 1'b1;
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL timeout obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        send_frame(8'h4D, 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg())
            $display("FAIL after_timeout obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        do_read();
        do_clr();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h16, 1'b0, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(i[0]);
        ps2d = 1'b1;
        rst = 1'b0;
        model_reset();
        cyc(3);
        total++;
        if (obs !== exp_vec() || debug_out !== 32'h0)
            $display("FAIL reset_mid obs=%h exp=%h dbg=%h", obs, exp_vec(), debug_out);
        else passed++;
        rst = 1'b1;
        cyc(5);
        send_frame(8'h2A, 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || debug_out !== exp_dbg() || code !== 8'h2A)
            $display("FAIL after_reset_mid obs=%h exp=%h dbg=%h exp_dbg=%h", obs, exp_vec(), debug_out, exp_dbg());
        else passed++;
        do_read();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 6) == 0) b = 8'hE0;
                if ($urandom_range(0, 6) == 0) b = 8'hF0;
                send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
            end else if (r < 9) do_read();
            else do_clr();
            total++;
            if (obs !== exp_vec() || debug_out !== exp_dbg())
                $display("FAIL random%0d obs=%h exp=%h dbg=%h exp_dbg=%h", n, obs, exp_vec(), debug_out, exp_dbg());
            else passed++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_bad_frames();
        test_overflow();
        test_glitch_timeout();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_fifo.md
# ps2_kbd_fifo

PS/2 keyboard receiver with glitch filtering, frame checking, scan-code prefix decoding and a parametrised show-ahead FIFO. It is the parametrised successor to the single-byte keyboard front end. It sits between the board `ps2c`/`ps2d` pins and consumers such as the piano note logic or the UART reporter. A 32-bit debug word drives the eight 7-segment digits directly.

## Interface
- `DEPTH_LOG2`, 3: FIFO holds 2^DEPTH_LOG2 entries; legal range 1..4.
- `FILTER_LEN`, 4: number of consecutive identical samples required to change the filtered PS/2 clock; legal range 2..16.
- `TIMEOUT`, 20000: clk cycles allowed between frame bits before the frame is aborted.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `ps2c` input 1: raw PS/2 clock (asynchronous).
- `ps2d` input 1: raw PS/2 data (asynchronous).
- `rd_en` input 1: pop the head entry; ignored while `empty`.
- `clr_err` input 1: one-cycle pulse that clears the sticky error flags.
- `code_valid` output 1: head entry present; equals `!empty`.
- `code` output 8: head scan code (prefixes stripped).
- `is_ext` output 1: head entry was preceded by E0.
- `is_break` output 1: head entry was preceded by F0.
- `empty` output 1: FIFO empty.
- `full` output 1: FIFO full.
- `count` output DEPTH_LOG2+1: number of entries currently held.
- `overflow` output 1: sticky; a push was dropped because the FIFO was full.
- `parity_err` output 1: sticky; a frame failed odd parity.
- `frame_err` output 1: sticky; bad stop bit or timeout.
- `debug_out` output 32:
  - [7:0] head `code`.
  - [15:8] last raw received byte.
  - [19:16] `count` zero-extended or truncated to 4 bits.
  - [23:20] {`overflow`, `parity_err`, `frame_err`, `is_break`}.
  - [31:24] 0.

## Operation
- **Synchronisers:** `ps2c` and `ps2d` each pass through 2 flip-flops.
- **Clock filter:** a FILTER_LEN-sample shift register tracks synced `ps2c`.
  - The filtered clock goes 0 when all samples are 0 and goes 1 when all samples are 1; otherwise it holds.
  - A 1→0 transition of the filtered clock produces a one-cycle `fall` pulse. Synced `ps2d` is sampled on `fall`.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on `fall` with data=0 go to DATA, bit counter=0. On `fall` with data=1, stay in IDLE (spurious start).
  - DATA: shift bits in LSB first. After the 8th bit go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on `fall` return to IDLE.
    - If data bit 1 is the stop bit and the odd parity over data plus parity bit holds, the byte is complete and `debug_out[15:8]` updates.
    - A parity failure sets `parity_err` and discards the byte.
    - A stop bit of 0 sets `frame_err` and discards the byte. If both fail, both flags set.
  - Timeout: in any non-IDLE state, a cycle counter resets on each `fall`. When it reaches TIMEOUT the FSM returns to IDLE, sets `frame_err` and discards partial data.
- **Prefix decoder**, run on each complete byte:
  - E0 sets `ext_pend`.
  - F0 sets `brk_pend`.
  - Any other byte pushes {`ext_pend`, `brk_pend`, byte} into the FIFO, then clears both pending flags.
  - The E0,F0,xx sequence yields `is_ext`=`is_break`=1.
  - A dropped push (overflow) still clears the pending flags.
- **FIFO**, show-ahead, 10-bit entries:
  - `code`, `is_ext` and `is_break` are valid when `!empty`, and are 0 when empty.
  - Push while full is dropped and sets `overflow`.
  - Push and pop in the same cycle while full: both happen and `count` is unchanged.
  - Push and `rd_en` in the same cycle while empty: only the push happens.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- **Sticky flags:** `clr_err` clears all three. If a set and `clr_err` occur in the same cycle, the set wins.

## Timing
- **Reset:** while `rst`=0 at a clock edge, the block enters this state:
  - FSM in IDLE; filter register and filtered clock all 1; counters and pending flags 0; FIFO pointers 0.
  - `empty`=1; `full`=0; `count`=0; `code_valid`=0; `code`=0; `is_ext`=0; `is_break`=0.
  - All error flags 0; `debug_out`=0.
  - A reset in the middle of a frame discards it.
- **Raw edge to `fall`:** a raw `ps2c` fall held stable produces `fall` 2+FILTER_LEN cycles later.
- **Write latency:** if the stop-bit `fall` occurs in cycle N, the FIFO write is at the end of N+1 and `code_valid`, `count` and `debug_out` reflect the new entry from cycle N+2.
- **Read:** with `rd_en` high in cycle M, the next head (or `empty`) is visible from cycle M+1.
- **Error flags:** the flags set visibly in the cycle after the detecting `fall` or the timeout.
- **Throughput:** PS/2 bit periods (≥30 µs) far exceed the internal latency. No back-pressure reaches the keyboard.

## Test plan
- **Make code:** send frame 0x1C (parity 0, stop 1) → `code_valid`=1, `code`=0x1C, `is_ext`=0, `is_break`=0, `count`=1. Then `rd_en` → `empty`=1.
- **Extended break:** send E0, F0, 0x75 → exactly one entry, `code`=0x75, `is_ext`=1, `is_break`=1, `debug_out[15:8]`=0x75.
- **Bad frames:** 0x1C with wrong parity → no entry, `parity_err`=1. Then stop bit 0 → `frame_err`=1. Then `clr_err` → both 0.
- **Overflow:** with DEPTH_LOG2=3, send 9 make codes 0x01..0x09 without reading → `full`=1, `count`=8, `overflow`=1. The reads return 0x01..0x08 in order.
- **Glitch and timeout:** 2-cycle low pulses on `ps2c` with FILTER_LEN=4 → no `fall`, no entry. Sending a start plus 3 bits then idling > TIMEOUT → `frame_err`=1, FSM in IDLE, and the next good frame is received correctly.
- **Reset mid-frame:** pull `rst` low after 5 data bits → all outputs at reset values; a subsequent full frame 0x2A is received as `code`=0x2A.
